uart_ram_loader: RTL and testbench

UART_RAM_LOADER -- requirements
Module: uart_ram_loader

---
 rtl/uart_ram_loader.sv | 152 +++++++++++++++
 tb/tb_uart_ram_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Streams byte pairs from a UART receiver into RAM2 as 16-bit little-endian words.
// Optional running checksum enabled by defining UART_RAM_LOADER_CHECKSUM_EN.
module uart_ram_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [17:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        data_ready,
  input  logic [7:0]  uart_data,
  output logic        rdn,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data2,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written,
  output logic [15:0] checksum
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, STROBE, CAPTURE, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t              state, state_next;
  logic                phase;
  logic                hi_byte;
  logic                load;
  logic                commit;
  logic                drive;
  logic [17:0]         addr;
  logic [15:0]         remaining;
  logic [DATA_W-1:0]   word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Strobes are decoded from state so an asynchronous reset releases them at once.
  always_comb begin
    state_next = state;
    rdn        = 1'b1;
    ram2EN     = 1'b1;
    ram2OE     = 1'b1;
    ram2WE     = 1'b1;
    drive      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    load       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load       = 1'b1;
          state_next = (word_count == 16'd0) ? DONE : WAIT_RDY;
        end
      end
      WAIT_RDY: if (data_ready) state_next = STROBE;
      STROBE: begin
        rdn = 1'b0;
        if (phase) state_next = CAPTURE;
      end
      CAPTURE:  state_next = hi_byte ? WR_SETUP : WAIT_RDY;
      WR_SETUP: begin
        ram2EN     = 1'b0;
        drive      = 1'b1;
        state_next = WR_PULSE;
      end
      WR_PULSE: begin
        ram2EN = 1'b0;
        ram2WE = 1'b0;
        drive  = 1'b1;
        if (phase) state_next = WR_HOLD;
      end
      WR_HOLD: begin
        ram2EN     = 1'b0;
        drive      = 1'b1;
        commit     = 1'b1;
        state_next = (remaining == 16'd1) ? DONE : WAIT_RDY;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      load       = 1'b0;
      commit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase         <= 1'b0;
      hi_byte       <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      words_written <= '0;
    end else begin
      phase <= (state == STROBE || state == WR_PULSE) && !phase && !abort;
      if (load) begin
        addr          <= base_addr;
        remaining     <= word_count;
        words_written <= '0;
        hi_byte       <= 1'b0;
      end else if (abort) begin
        hi_byte <= 1'b0;
      end else if (state == CAPTURE) begin
        hi_byte <= !hi_byte;
      end else if (commit) begin
        addr          <= addr + 18'd1;
        remaining     <= remaining - 16'd1;
        words_written <= words_written + 16'd1;
      end
    end
  end

  // Assembly register carries data only; a stale partial word is overwritten on reload.
  always_ff @(posedge clk) begin
    if (state == CAPTURE && !abort) begin
      if (hi_byte) word[15:8] <= uart_data;
      else         word[7:0]  <= uart_data;
    end
  end

`ifdef UART_RAM_LOADER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sum <= '0;
    else if (load)   sum <= '0;
    else if (commit) sum <= sum + word;
  end

  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif

  assign ram_addr2 = addr;
  assign ram_data2 = drive ? word : 16'hzzzz;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: byte assembly, RAM write strobes, wrap, abort, reset, busy start.
module tb_uart_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [17:0] base_addr;
  logic [15:0] word_count;
  logic        data_ready;
  logic [7:0]  uart_data;
  logic        rdn;
  logic [17:0] ram_addr2;
  wire  [15:0] ram_data2;
  logic        ram2EN, ram2OE, ram2WE;
  logic        busy, done;
  logic [15:0] words_written, checksum;

  logic        probe = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          rdn_lows = 0;
  int          we_lows = 0;
  int          done_cnt = 0;
  logic        we_prev = 1'b1;
  logic [17:0] wr_addr[$];
  logic [15:0] wr_data[$];

  always #5 clk = ~clk;

  // A known pattern shows through only when the DUT releases the bus.
  assign ram_data2 = probe ? 16'hC3C3 : 16'hzzzz;

  uart_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .data_ready(data_ready), .uart_data(uart_data), .rdn(rdn),
    .ram_addr2(ram_addr2), .ram_data2(ram_data2),
    .ram2EN(ram2EN), .ram2OE(ram2OE), .ram2WE(ram2WE),
    .busy(busy), .done(done), .words_written(words_written), .checksum(checksum)
  );

  always @(negedge clk) begin
    if (!ram2WE && we_prev && !ram2EN) begin
      wr_addr.push_back(ram_addr2);
      wr_data.push_back(ram_data2);
    end
    we_prev = ram2WE;
    if (!rdn)    rdn_lows++;
    if (!ram2WE) we_lows++;
    if (done)    done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [17:0] a, input logic [15:0] n);
    base_addr  = a;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    uart_data  = b;
    data_ready = 1'b1;
    for (int i = 0; i < 100 && rdn; i++) tick();
    check("rdn_strobe_seen", {31'd0, rdn}, 32'd0);
    data_ready = 1'b0;
    n = 0;
    while (!rdn && n < 10) begin
      n++;
      tick();
    end
    check("rdn_low_cycles", n, 32'd2);
    tick();
  endtask

  task automatic wait_done;
    for (int i = 0; i < 200 && !done; i++) tick();
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_bus_released(input string tag);
    probe = 1'b1;
    #1;
    check(tag, {16'd0, ram_data2}, 32'h0000C3C3);
    probe = 1'b0;
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef UART_RAM_LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  initial begin
    int d0, r0, w0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    data_ready = 1'b0; uart_data = '0;
    #3;
    check("rst_rdn", {31'd0, rdn}, 32'd1);
    check("rst_en", {31'd0, ram2EN}, 32'd1);
    check("rst_oe", {31'd0, ram2OE}, 32'd1);
    check("rst_we", {31'd0, ram2WE}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {14'd0, ram_addr2}, 32'd0);
    check("rst_ww", {16'd0, words_written}, 32'd0);
    check("rst_cs", {16'd0, checksum}, 32'd0);
    check_bus_released("rst_bus_z");
    #3 rst = 1'b1;
    tick();

    // Basic two-word load
    wr_addr.delete(); wr_data.delete();
    pulse_start(18'h00100, 16'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
    wait_done();
    d0 = done_cnt;
    tick();
    check("t1_done_width", {31'd0, done}, 32'd0);
    check("t1_done_cnt", done_cnt - d0, 32'd1);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_nwr", wr_addr.size(), 32'd2);
    check("t1_a0", {14'd0, wr_addr[0]}, 32'h00100);
    check("t1_d0", {16'd0, wr_data[0]}, 32'h1234);
    check("t1_a1", {14'd0, wr_addr[1]}, 32'h00101);
    check("t1_d1", {16'd0, wr_data[1]}, 32'h5678);
    check("t1_ww", {16'd0, words_written}, 32'd2);
    check("t1_cs", {16'd0, checksum}, {16'd0, exp_sum(16'h68AC)});
    check("t1_oe", {31'd0, ram2OE}, 32'd1);

    // Zero-length load
    r0 = rdn_lows; w0 = we_lows;
    pulse_start(18'h00500, 16'd0);
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    check("t2_done_low", {31'd0, done}, 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_no_rdn", rdn_lows - r0, 32'd0);
    check("t2_no_we", we_lows - w0, 32'd0);
    check("t2_ww", {16'd0, words_written}, 32'd0);
    check("t2_cs", {16'd0, checksum}, 32'd0);

    // Address wrap at top of RAM
    wr_addr.delete(); wr_data.delete();
    pulse_start(18'h3FFFF, 16'd2);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    wait_done();
    tick();
    check("t3_nwr", wr_addr.size(), 32'd2);
    check("t3_a0", {14'd0, wr_addr[0]}, 32'h3FFFF);
    check("t3_a1", {14'd0, wr_addr[1]}, 32'h00000);
    check("t3_d1", {16'd0, wr_data[1]}, 32'h0002);
    check("t3_cs", {16'd0, checksum}, {16'd0, exp_sum(16'h0003)});

    // Abort after first byte of second word
    d0 = done_cnt;
    pulse_start(18'h00200, 16'd2);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    abort = 1'b1;
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_rdn", {31'd0, rdn}, 32'd1);
    check("t4_we", {31'd0, ram2WE}, 32'd1);
    check("t4_en", {31'd0, ram2EN}, 32'd1);
    check_bus_released("t4_bus_z");
    start = 1'b1;
    tick();
    check("t4_abort_beats_start", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;
    tick();
    check("t4_no_done", done_cnt - d0, 32'd0);
    check("t4_ww", {16'd0, words_written}, 32'd1);
    check("t4_addr", {14'd0, ram_addr2}, 32'h00201);
    check("t4_cs", {16'd0, checksum}, {16'd0, exp_sum(16'hBBAA)});

    // Asynchronous reset during the write pulse
    pulse_start(18'h00300, 16'd1);
    send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < 20 && ram2WE; i++) tick();
    check("t5_we_low", {31'd0, ram2WE}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("t5_we", {31'd0, ram2WE}, 32'd1);
    check("t5_en", {31'd0, ram2EN}, 32'd1);
    check("t5_rdn", {31'd0, rdn}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_addr", {14'd0, ram_addr2}, 32'd0);
    check("t5_ww", {16'd0, words_written}, 32'd0);
    check("t5_cs", {16'd0, checksum}, 32'd0);
    check_bus_released("t5_bus_z");
    rst = 1'b1;
    tick();

    // Start while busy is ignored
    wr_addr.delete(); wr_data.delete();
    pulse_start(18'h00400, 16'd1);
    tick();
    pulse_start(18'h00000, 16'd5);
    send_byte(8'h0D); send_byte(8'hF0);
    wait_done();
    tick();
    check("t6_nwr", wr_addr.size(), 32'd1);
    check("t6_a0", {14'd0, wr_addr[0]}, 32'h00400);
    check("t6_d0", {16'd0, wr_data[0]}, 32'hF00D);
    check("t6_ww", {16'd0, words_written}, 32'd1);
    check("t6_cs", {16'd0, checksum}, {16'd0, exp_sum(16'hF00D)});
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
